lsu_mc: RTL and testbench

Parametrised multicycle load/store unit placed between the core datapath (address/B register, load/store result mux) and the data memory port. It replaces the fixed-width, single-cycle-assumed load/store path with a request/ack handshake that supports memory wait states, byte enables, and 32- or 64-bit data. Misaligned accesses that cross a word boundary are split into two beats. A timeout raises an error, so the core FSM can stall on resp_valid instead of assuming fixed memory latency.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 72 +++++++
 rtl/lsu_mc.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_mc.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the multicycle load/store unit.
//   lsu_state_e : FSM states of lsu_mc
//   LB..SD      : RISC-V load/store funct3 encodings
//   size_mask() : byte-lane mask for an access size (fu3[1:0])
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        BEAT0,
        BEAT1,
        RESP
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    localparam int unsigned MASK_W = 16;

    // One bit per byte touched by an access of 1/2/4/8 bytes.
    function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] sz);
        logic [MASK_W-1:0] m;
        case (sz)
            2'd0:    m = 16'h0001;
            2'd1:    m = 16'h0003;
            2'd2:    m = 16'h000F;
            default: m = 16'h00FF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for lsu_mc.
//   fu3, ofs        : access size/sign and byte offset within the word
//   wdata           : LSB-aligned store data
//   rd_lo, rd_hi    : beat0 / beat1 read data (rd_hi = 0 for single beat)
//   split_c         : access crosses a word boundary
//   be0_c, be1_c    : byte enables for beat0 / beat1
//   wd0_c, wd1_c    : lane-aligned write data for beat0 / beat1
//   ld_data_c       : extracted, sign/zero-extended load result
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned NB    = DATA_W / 8,
    localparam int unsigned OFS_W = $clog2(NB)
) (
    input  logic [2:0]        fu3,
    input  logic [OFS_W-1:0]  ofs,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rd_lo,
    input  logic [DATA_W-1:0] rd_hi,
    output logic              split_c,
    output logic [NB-1:0]     be0_c,
    output logic [NB-1:0]     be1_c,
    output logic [DATA_W-1:0] wd0_c,
    output logic [DATA_W-1:0] wd1_c,
    output logic [DATA_W-1:0] ld_data_c
);

    localparam int unsigned BW = 2 * NB;
    localparam int unsigned EW = OFS_W + 2;

    logic [MASK_W-1:0]   mask;
    logic [BW-1:0]       be_wide;
    logic [2*DATA_W-1:0] wd_wide;
    logic [2*DATA_W-1:0] rd_wide;
    logic [DATA_W-1:0]   raw;
    logic [DATA_W-1:0]   keep;
    logic [EW-1:0]       end_pos;
    logic                sgn;

    // Lane masks and data are shifted across a double-width window; the
    // upper half belongs to the second beat.
    always_comb begin
        mask    = size_mask(fu3[1:0]);
        end_pos = EW'(ofs) + (EW'(1) << fu3[1:0]);
        split_c = (end_pos > EW'(NB));

        be_wide = BW'(mask) << ofs;
        be0_c   = be_wide[NB-1:0];
        be1_c   = be_wide[BW-1:NB];

        wd_wide = {DATA_W'(0), wdata} << {ofs, 3'b000};
        wd0_c   = wd_wide[DATA_W-1:0];
        wd1_c   = wd_wide[2*DATA_W-1:DATA_W];
    end

    // Sign bit is the top bit of the highest byte kept by the size mask.
    always_comb begin
        rd_wide = {rd_hi, rd_lo} >> {ofs, 3'b000};
        raw     = rd_wide[DATA_W-1:0];
        keep    = '0;
        sgn     = 1'b0;
        for (int i = 0; i < int'(NB); i++) begin
            if (mask[i]) begin
                keep[8*i +: 8] = 8'hFF;
                sgn            = raw[8*i+7];
            end
        end
        ld_data_c = (raw & keep) | (~keep & {DATA_W{sgn & ~fu3[2]}});
    end

endmodule

// File: rtl/lsu_mc.sv
// Multicycle load/store unit between the core and a req/ack data memory.
//   clk_in, rst_in                : clock, async active-low reset
//   req_valid/ready/we/fu3/addr/wdata : core request (accepted on valid&ready)
//   resp_valid/rdata/err          : one-cycle completion pulse and result
//   mem_req/we/addr/be/wdata      : memory beat request, held until mem_ack
//   mem_ack/rdata/err             : memory beat completion
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = 32,
    parameter bit          MISALIGNED_EN = 1'b1,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_fu3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W/8-1:0]  mem_be,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(NB);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          fu3_q, fu3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                req_ready_d, resp_valid_d, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_d;
    logic                mem_req_d, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [NB-1:0]       mem_be_d;
    logic [DATA_W-1:0]   mem_wdata_d;

    logic                split_c, illegal_c;
    logic [NB-1:0]       be0_c, be1_c;
    logic [DATA_W-1:0]   wd0_c, wd1_c, ld_data_c, rd_lo_c, rd_hi_c;
    logic [ADDR_W-1:0]   base_c;

    // The final beat's data comes straight from the bus so the result is
    // ready on the ack edge.
    assign rd_lo_c = (state_q == BEAT0) ? mem_rdata : rdata0_q;
    assign rd_hi_c = (state_q == BEAT1) ? mem_rdata : '0;
    assign base_c  = {addr_q[ADDR_W-1:OFS_W], OFS_W'(0)};

    assign illegal_c = (fu3_q == 3'b111)
                    || (we_q && fu3_q[2])
                    || ((DATA_W == 32) && ((fu3_q == LD) || (fu3_q == LWU)));

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .fu3       (fu3_q),
        .ofs       (addr_q[OFS_W-1:0]),
        .wdata     (wdata_q),
        .rd_lo     (rd_lo_c),
        .rd_hi     (rd_hi_c),
        .split_c   (split_c),
        .be0_c     (be0_c),
        .be1_c     (be1_c),
        .wd0_c     (wd0_c),
        .wd1_c     (wd1_c),
        .ld_data_c (ld_data_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        fu3_d        = fu3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_be_d     = mem_be;
        mem_wdata_d  = mem_wdata;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    we_d        = req_we;
                    fu3_d       = req_fu3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    state_d     = CHECK;
                end
            end

            CHECK: begin
                if (illegal_c || (split_c && !MISALIGNED_EN)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    state_d     = BEAT0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = we_q;
                    mem_addr_d  = base_c;
                    mem_be_d    = be0_c;
                    mem_wdata_d = wd0_c;
                    cnt_d       = '0;
                end
            end

            BEAT0, BEAT1: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if (mem_err) begin
                        state_d      = RESP;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if ((state_q == BEAT0) && split_c) begin
                        state_d     = BEAT1;
                        rdata0_d    = mem_rdata;
                        mem_addr_d  = base_c + ADDR_W'(NB);
                        mem_be_d    = be1_c;
                        mem_wdata_d = wd1_c;
                    end else begin
                        state_d      = RESP;
                        mem_req_d    = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = we_q ? '0 : ld_data_c;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    // State, capture and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            fu3_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            fu3_q      <= fu3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            cnt_q      <= cnt_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_be     <= mem_be_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_mc.sv
// Self-checking bench for lsu_mc: byte-level memory model with wait states,
// scoreboard of expected responses, directed beat/latency/error/reset checks.
module tb_lsu_mc;
    import lsu_pkg::*;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        req_valid = 1'b0, req_valid_na = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_fu3 = 3'b000;
    logic [31:0] req_addr = '0, req_wdata = '0;

    logic        req_ready, resp_valid, resp_err, mem_req, mem_we, mem_ack, mem_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        req_ready_na, resp_valid_na, resp_err_na, mem_req_na, mem_we_na;
    logic [31:0] resp_rdata_na, mem_addr_na, mem_wdata_na;
    logic [3:0]  mem_be_na;
    logic [31:0] mem_rdata_na = 32'h5A5A_5A5A;
    logic        mem_err_na = 1'b0;

    logic [7:0]  mbytes [0:1023];
    logic [7:0]  shadow [0:1023];
    logic [9:0]  ma;
    int          wcnt = 0;
    int          wait_cycles = 0;
    bit          no_ack = 1'b0, err_mode = 1'b0;

    int          resp_cnt = 0, req_cycles = 0, ack_cnt = 0, na_req_cycles = 0;
    int          n_checks = 0, n_pass = 0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    lsu_mc #(.DATA_W(32), .ADDR_W(32), .MISALIGNED_EN(1'b1), .TIMEOUT(4)) dut (
        .clk_in(clk), .rst_in(rst_in),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_fu3(req_fu3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    lsu_mc #(.DATA_W(32), .ADDR_W(32), .MISALIGNED_EN(1'b0), .TIMEOUT(4)) dut_na (
        .clk_in(clk), .rst_in(rst_in),
        .req_valid(req_valid_na), .req_ready(req_ready_na), .req_we(req_we),
        .req_fu3(req_fu3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_na), .resp_rdata(resp_rdata_na), .resp_err(resp_err_na),
        .mem_req(mem_req_na), .mem_we(mem_we_na), .mem_addr(mem_addr_na), .mem_be(mem_be_na),
        .mem_wdata(mem_wdata_na), .mem_ack(mem_req_na), .mem_rdata(mem_rdata_na),
        .mem_err(mem_err_na)
    );

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            256: return 8'hEF;
            257: return 8'hBE;
            258: return 8'hAD;
            259: return 8'hDE;
            260: return 8'hBB;
            261, 262, 263: return 8'h00;
            default: return 8'(i * 37 + 5);
        endcase
    endfunction

    // Memory model: ack after wait_cycles cycles of mem_req, reloaded in reset.
    assign ma        = {mem_addr[9:2], 2'b00};
    assign mem_ack   = mem_req && !no_ack && (wcnt >= wait_cycles);
    assign mem_err   = mem_ack && err_mode;
    assign mem_rdata = {mbytes[ma + 10'd3], mbytes[ma + 10'd2], mbytes[ma + 10'd1], mbytes[ma]};

    always @(posedge clk) begin
        if (!rst_in) begin
            wcnt <= 0;
            for (int i = 0; i < 1024; i++) mbytes[i] <= init_byte(i);
        end else begin
            if (mem_req && !mem_ack) wcnt <= wcnt + 1;
            else                     wcnt <= 0;
            if (mem_ack && mem_we && !err_mode)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mbytes[int'(ma) + b] <= mem_wdata[8*b +: 8];
        end
    end

    always @(posedge clk) begin
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (mem_req)    req_cycles <= req_cycles + 1;
        if (mem_ack)    ack_cnt <= ack_cnt + 1;
        if (mem_req_na) na_req_cycles <= na_req_cycles + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] fu3, input logic [31:0] addr);
        int n, base;
        logic [31:0] v;
        n    = 1 << fu3[1:0];
        base = int'(addr[9:0]);
        v    = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = shadow[base + k];
        if (!fu3[2] && n < 4 && v[8*n-1])
            for (int k = 8 * n; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic init_shadow();
        for (int i = 0; i < 1024; i++) shadow[i] = init_byte(i);
    endtask

    // Push the expected response, then hand the request to the DUT.
    task automatic issue(input logic we, input logic [2:0] fu3, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit force_err);
        exp_t e;
        int   n, base;
        bit   rdy;
        n       = 1 << fu3[1:0];
        base    = int'(addr[9:0]);
        e.err   = force_err || (fu3 == 3'b011) || (fu3 == 3'b110) || (fu3 == 3'b111)
                  || (we && fu3[2]);
        e.rdata = '0;
        if (!e.err) begin
            if (we) for (int k = 0; k < n; k++) shadow[base + k] = wdata[8*k +: 8];
            else    e.rdata = ref_load(fu3, addr);
        end
        sb_q.push_back(e);
        rdy = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (req_ready) begin rdy = 1'b1; break; end
        end
        if (!rdy) check("req_ready_wait", 0, 1);
        req_we = we; req_fu3 = fu3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic finish_resp(input string tag);
        exp_t e;
        bit   seen;
        int   rc0;
        seen = 1'b0;
        rc0  = resp_cnt;
        for (int i = 0; i < 64; i++) begin
            if (resp_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check({tag, "_seen"}, 64'(seen), 1);
        if (seen) begin
            check({tag, "_rdata"}, 64'(resp_rdata), 64'(e.rdata));
            check({tag, "_err"}, 64'(resp_err), 64'(e.err));
        end
        @(negedge clk);
        @(negedge clk);
        check({tag, "_pulses"}, 64'(resp_cnt - rc0), 1);
    endtask

    initial begin
        int  rc0, ac0, nc0;
        bit  seen;

        init_shadow();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk) rst_in = 1'b1;

        // Aligned LW, zero-wait: mem_req in cycle 2, response in cycle 3.
        issue(1'b0, LW, 32'h100, 32'h0, 1'b0);
        @(negedge clk);
        check("lw_c1_mem_req", mem_req, 0);
        check("lw_c1_ready", req_ready, 0);
        @(negedge clk);
        check("lw_c2_mem_req", mem_req, 1);
        check("lw_c2_addr", mem_addr, 32'h100);
        check("lw_c2_be", mem_be, 4'b1111);
        check("lw_c2_we", mem_we, 0);
        @(negedge clk);
        check("lw_c3_resp", resp_valid, 1);
        finish_resp("lw_100");
        check("lw_after_ready", req_ready, 1);

        issue(1'b1, SW, 32'h100, 32'hAA00_0000, 1'b0);
        finish_resp("sw_100");

        // Split LH across 0x103/0x104.
        issue(1'b0, LH, 32'h103, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("lh_b0_addr", mem_addr, 32'h100);
        check("lh_b0_be", mem_be, 4'b1000);
        @(negedge clk);
        check("lh_b1_addr", mem_addr, 32'h104);
        check("lh_b1_be", mem_be, 4'b0001);
        check("lh_b1_rdata_bus", mem_rdata, 32'h0000_00BB);
        check("lh_value_model", ref_load(LH, 32'h103), 32'hFFFF_BBAA);
        finish_resp("lh_103");
        issue(1'b0, LHU, 32'h103, 32'h0, 1'b0);
        finish_resp("lhu_103");

        // SB into lane 2.
        issue(1'b1, SB, 32'h102, 32'h1234_5677, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("sb_addr", mem_addr, 32'h100);
        check("sb_be", mem_be, 4'b0100);
        check("sb_lane", mem_wdata[23:16], 8'h77);
        check("sb_we", mem_we, 1);
        finish_resp("sb_102");
        issue(1'b0, LW, 32'h100, 32'h0, 1'b0);
        finish_resp("lw_after_sb");

        // Split store and loads with wait states just under the timeout.
        wait_cycles = 3;
        issue(1'b1, SW, 32'h106, 32'h1122_3344, 1'b0);
        finish_resp("sw_106");
        issue(1'b0, LW, 32'h106, 32'h0, 1'b0);
        finish_resp("lw_106");
        wait_cycles = 1;
        issue(1'b1, SH, 32'h10B, 32'h0000_80F0, 1'b0);
        finish_resp("sh_10b");
        issue(1'b0, LH, 32'h10B, 32'h0, 1'b0);
        finish_resp("lh_10b");
        issue(1'b0, LB, 32'h10C, 32'h0, 1'b0);
        finish_resp("lb_10c");
        issue(1'b0, LBU, 32'h104, 32'h0, 1'b0);
        finish_resp("lbu_104");
        issue(1'b0, LB, 32'h12F, 32'h0, 1'b0);
        finish_resp("lb_12f");
        wait_cycles = 0;

        // Ack one cycle too late: timeout on beat0, beat1 never issued.
        wait_cycles = 4;
        rc0 = req_cycles; ac0 = ack_cnt;
        issue(1'b0, LH, 32'h103, 32'h0, 1'b1);
        finish_resp("to_lh");
        check("to_req_cycles", 64'(req_cycles - rc0), 4);
        check("to_acks", 64'(ack_cnt - ac0), 0);
        check("to_mem_req_low", mem_req, 0);
        wait_cycles = 0;
        no_ack = 1'b1;
        rc0 = req_cycles;
        issue(1'b1, SW, 32'h100, 32'hFFFF_FFFF, 1'b1);
        finish_resp("to_noack");
        check("to_noack_cycles", 64'(req_cycles - rc0), 4);
        no_ack = 1'b0;

        // Bus error on beat0 of a split access aborts it.
        err_mode = 1'b1;
        rc0 = req_cycles; ac0 = ack_cnt;
        issue(1'b0, LW, 32'h101, 32'h0, 1'b1);
        finish_resp("merr");
        check("merr_acks", 64'(ack_cnt - ac0), 1);
        check("merr_req_cycles", 64'(req_cycles - rc0), 1);
        err_mode = 1'b0;
        issue(1'b0, LW, 32'h100, 32'h0, 1'b0);
        finish_resp("lw_after_to");

        // Illegal encodings never reach memory.
        rc0 = req_cycles;
        issue(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
        finish_resp("ill_ld");
        issue(1'b0, 3'b111, 32'h100, 32'h0, 1'b0);
        finish_resp("ill_111");
        issue(1'b1, 3'b100, 32'h100, 32'h0, 1'b0);
        finish_resp("ill_sbu");
        issue(1'b0, 3'b110, 32'h100, 32'h0, 1'b0);
        finish_resp("ill_lwu");
        check("ill_no_mem", 64'(req_cycles - rc0), 0);

        // Instance with splitting disabled.
        nc0 = na_req_cycles;
        req_we = 1'b0; req_fu3 = LW; req_addr = 32'h102; req_wdata = '0;
        @(negedge clk);
        check("na_ready", req_ready_na, 1);
        req_valid_na = 1'b1;
        @(posedge clk);
        #1 req_valid_na = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (resp_valid_na) begin seen = 1'b1; break; end
        end
        check("na_mis_seen", 64'(seen), 1);
        check("na_mis_err", resp_err_na, 1);
        check("na_mis_rdata", resp_rdata_na, 0);
        repeat (2) @(negedge clk);
        check("na_mis_no_mem", 64'(na_req_cycles - nc0), 0);
        req_addr = 32'h100;
        req_valid_na = 1'b1;
        @(posedge clk);
        #1 req_valid_na = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (resp_valid_na) begin seen = 1'b1; break; end
        end
        check("na_al_seen", 64'(seen), 1);
        check("na_al_err", resp_err_na, 0);
        check("na_al_rdata", resp_rdata_na, 32'h5A5A_5A5A);
        repeat (2) @(negedge clk);
        check("na_al_mem", 64'(na_req_cycles - nc0), 1);

        // Reset while beat1 is waiting: no response, clean restart.
        wait_cycles = 3;
        rc0 = resp_cnt;
        issue(1'b0, LH, 32'h103, 32'h0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'h104) begin seen = 1'b1; break; end
        end
        check("rst_b1_reached", 64'(seen), 1);
        #2 rst_in = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_resp", resp_valid, 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_in = 1'b1;
        init_shadow();
        wait_cycles = 0;
        repeat (3) @(negedge clk);
        check("rst_no_resp", 64'(resp_cnt - rc0), 0);
        check("rst_after_ready", req_ready, 1);
        issue(1'b0, LW, 32'h100, 32'h0, 1'b0);
        finish_resp("lw_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
